uart_tx_feeder: RTL

//   Byte buffer and request sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder_pkg.sv | 13 +
 rtl/uart_tx_feeder_if.sv | 22 ++
 rtl/uart_tx_feeder_sync_fifo.sv | 97 +++++++++
 rtl/uart_tx_feeder.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared UART types: data width and feeder FSM encodings
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Feeder sequencer states; encodings are fixed so they read the same in waveforms
  typedef enum logic [1:0] {
    FEED_IDLE = 2'b00,
    FEED_REQ  = 2'b01,
    FEED_WAIT = 2'b10
  } feed_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - req/busy byte handshake between the feeder and uart_tx
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic                   tx_req;
  logic [UART_DATA_W-1:0] tx_byte;
  logic                   tx_busy;

  // The feeder is the sole driver of req and byte; the transmitter answers with busy
  modport master (
    output tx_req,
    output tx_byte,
    input  tx_busy
  );

  modport slave (
    input  tx_req,
    input  tx_byte,
    output tx_busy
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - generic single-clock FIFO with flush and registered read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              wr_ok;
  logic              rd_ok;

  // A write while full is dropped even if a read frees a slot on the same edge;
  // flush overrides both strobes so the queue is left cleanly empty.
  assign wr_ok = wr_en & ~full_q & ~flush;
  assign rd_ok = rd_en & ~empty_q & ~flush;

  // Next pointer/occupancy state; full and empty are decoded from the next count
  // so they come straight out of flops
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // Pointer, count, flag and read-data registers; rd_data is not cleared by flush
  // so a byte already handed downstream stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and req/busy sequencer feeding uart_tx
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   overflow_clr,
  uart_tx_feeder_if.master       tx
);

  feed_state_e            state_q, state_d;
  logic                   tx_req_q, tx_req_d;
  logic                   overflow_q, overflow_d;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_count;
  logic [UART_DATA_W-1:0] fifo_rd_data;

  // The FIFO read register doubles as the tx_byte holding register: it only
  // loads on a pop, which happens only on the IDLE->REQ transition.
  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer: pop and raise req when idle with data and a quiet transmitter,
  // drop req once busy is seen, then wait for busy to clear before the next byte
  always_comb begin
    state_d  = state_q;
    tx_req_d = tx_req_q;
    pop      = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (!fifo_empty && !tx.tx_busy && !flush) begin
          pop      = 1'b1;
          tx_req_d = 1'b1;
          state_d  = FEED_REQ;
        end
      end
      FEED_REQ: begin
        if (tx.tx_busy) begin
          tx_req_d = 1'b0;
          state_d  = FEED_WAIT;
        end
      end
      FEED_WAIT: begin
        if (!tx.tx_busy) begin
          state_d = FEED_IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = FEED_IDLE;
      end
    endcase
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_en && fifo_full && !flush) begin
      overflow_d = 1'b1;
    end
  end

  // FSM, request and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FEED_IDLE;
      tx_req_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx.tx_req  = tx_req_q;
  assign tx.tx_byte = fifo_rd_data;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign count      = fifo_count;
  assign overflow   = overflow_q;

endmodule
